// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller around an external 1-bit full-adder slice.
// Operands are fed LSB first; the carry lives in a flop between bits.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_sum,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_final,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] OVF_IDX  = CNT_W'((WIDTH > 1) ? WIDTH - 2 : 0);
    localparam bit HAS_OVF_BIT = (WIDTH > 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   res_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               ovf_c_q, ovf_c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_final_q, cout_final_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        res_shift = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            res_shift[i] = res_sr_q[i+1];
        end
        res_shift[WIDTH-1] = slice_sum;

        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        ovf_c_d      = ovf_c_q;
        cout_final_d = cout_final_q;
        ovf_d        = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sr_d   = op_a;
                    b_sr_d   = op_b;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    carry_d  = cin_init;
                    // For a single-bit add the carry into the MSB is cin_init itself.
                    ovf_c_d  = cin_init;
                end
            end
            S_RUN: begin
                res_sr_d = res_shift;
                carry_d  = slice_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (HAS_OVF_BIT && cnt_q == OVF_IDX) begin
                    ovf_c_d = slice_cout;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d      = S_DONE;
                    result_d     = res_shift;
                    cout_final_d = slice_cout;
                    ovf_d        = ovf_c_q ^ slice_cout;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            ovf_c_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cout_final_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            ovf_c_q      <= ovf_c_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cout_final_q <= cout_final_d;
            ovf_q        <= ovf_d;
        end
    end

    // Slice inputs come straight from flops, gated so they idle at zero.
    assign slice_a    = (state_q == S_RUN) & a_sr_q[0];
    assign slice_b    = (state_q == S_RUN) & b_sr_q[0];
    assign slice_cin  = (state_q == S_RUN) & carry_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign cout_final = cout_final_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: 8-bit and 1-bit instances, each
// driving a delayed full-adder slice model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic rst_n;

    logic       start8, c8, sa8, sb8, sc8, ss8, sco8, busy8, done8, cf8, ov8;
    logic [7:0] a8, b8, res8;
    logic       start1, c1, sa1, sb1, sc1, ss1, sco1, busy1, done1, cf1, ov1;
    logic [0:0] a1, b1, res1;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .cin_init(c8),
        .slice_a(sa8), .slice_b(sb8), .slice_cin(sc8), .slice_sum(ss8), .slice_cout(sco8),
        .busy(busy8), .done(done8), .result(res8), .cout_final(cf8), .ovf(ov8));

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .cin_init(c1),
        .slice_a(sa1), .slice_b(sb1), .slice_cin(sc1), .slice_sum(ss1), .slice_cout(sco1),
        .busy(busy1), .done(done1), .result(res1), .cout_final(cf1), .ovf(ov1));

    // Full-adder slices with a propagation delay far below the clock period.
    assign #3 {sco8, ss8} = {1'b0, sa8} + {1'b0, sb8} + {1'b0, sc8};
    assign #3 {sco1, ss1} = {1'b0, sa1} + {1'b0, sb1} + {1'b0, sc1};

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    int checks = 0;
    int failures = 0;

    function automatic exp_t model(int w, longint unsigned a, longint unsigned b, logic c);
        longint unsigned full, low, half;
        exp_t e;
        half   = 64'd1 << (w - 1);
        full   = a + b + 64'(c);
        low    = (a % half) + (b % half) + 64'(c);
        e.res  = 32'(full & ((64'd1 << w) - 1));
        e.co   = full[w];
        e.ov   = low[w-1] ^ full[w];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 32'(done8), 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("sb_res8", 32'(res8), e8.res);
                chk("sb_cout8", 32'(cf8), 32'(e8.co));
                chk("sb_ovf8", 32'(ov8), 32'(e8.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) chk("done1_unexpected", 32'(done1), 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("sb_res1", 32'(res1), e1.res);
                chk("sb_cout1", 32'(cf1), 32'(e1.co));
                chk("sb_ovf1", 32'(ov1), 32'(e1.ov));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int g = 0;
        while ((busy8 || done8) && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("issue8_idle_timeout", 32'(g), 32'd0);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        q8.push_back(model(8, 64'(a), 64'(b), c));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait8(input int poke_at, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            if (lat == poke_at) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'b1;
            end
            @(negedge clk);
            start8 = 1'b0;
            lat++;
        end
        if (!done8) chk("done8_timeout", 32'(done8), 32'd1);
        @(negedge clk);
        chk("done8_one_cycle", 32'(done8), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, t, first, second;
        rst_n = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; c8 = 0;
        start1 = 0; a1 = 0; b1 = 0; c1 = 0;
        #5 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_res8", 32'(res8), 0);
        chk("rst_cout8", 32'(cf8), 0);
        chk("rst_ovf8", 32'(ov8), 0);
        chk("rst_slice8", 32'({sa8, sb8, sc8}), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_res1", 32'(res1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue8(8'h5A, 8'h3C, 1'b0);
        wait8(0, lat, bc);
        chk("lat_5a3c", lat, 9);
        chk("busy_cycles_5a3c", bc, 8);
        chk("res_5a3c", 32'(res8), 32'h96);
        chk("cout_5a3c", 32'(cf8), 0);
        chk("ovf_5a3c", 32'(ov8), 1);

        issue8(8'hFF, 8'h01, 1'b0);
        wait8(0, lat, bc);
        chk("res_ff01", 32'(res8), 0);
        chk("cout_ff01", 32'(cf8), 1);
        chk("ovf_ff01", 32'(ov8), 0);
        issue8(8'h80, 8'h80, 1'b0);
        wait8(0, lat, bc);
        chk("res_8080", 32'(res8), 0);
        chk("cout_8080", 32'(cf8), 1);
        chk("ovf_8080", 32'(ov8), 1);

        issue8(8'h00, 8'h00, 1'b1);
        chk("cin_first_run", 32'(sc8), 1);
        @(negedge clk);
        chk("cin_second_run", 32'(sc8), 0);
        wait8(0, lat, bc);
        chk("res_0001", 32'(res8), 1);
        chk("cout_0001", 32'(cf8), 0);

        issue8(8'h11, 8'h22, 1'b0);
        wait8(3, lat, bc);
        chk("lat_ignored_start", lat, 9);
        chk("busy_ignored_start", bc, 8);
        chk("res_ignored_start", 32'(res8), 32'h33);
        chk("no_queued_start", 32'(busy8), 0);

        issue8(8'h77, 8'h99, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_before_abort", 32'(busy8), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_done", 32'(done8), 0);
        chk("abort_res", 32'(res8), 0);
        chk("abort_slice", 32'({sa8, sb8, sc8}), 0);
        void'(q8.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h12, 8'h34, 1'b0);
        wait8(0, lat, bc);
        chk("res_after_reset", 32'(res8), 32'h46);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            wait8(0, lat, bc);
            chk("lat_random", lat, 9);
        end

        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; start1 = 1'b1;
        q1.push_back(model(1, 64'd1, 64'd1, 1'b1));
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("lat_w1", lat, 2);
        chk("res_w1", 32'(res1), 1);
        chk("cout_w1", 32'(cf1), 1);
        chk("ovf_w1", 32'(ov1), 0);
        repeat (2) @(negedge clk);

        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        q1.push_back(model(1, 64'd1, 64'd0, 1'b0));
        q1.push_back(model(1, 64'd1, 64'd0, 1'b0));
        start1 = 1'b1;
        t = 0; first = -1; second = -1;
        while (second < 0 && t < 30) begin
            @(negedge clk);
            t++;
            if (done1) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        start1 = 1'b0;
        chk("w1_first_done", first, 2);
        chk("w1_b2b_gap", second - first, 3);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that sits directly around the 1-bit full-adder slice. It feeds the slice one operand bit pair plus the registered carry per clock, and consumes the slice's sum/cout outputs. It accumulates a WIDTH-bit result and holds the carry in a flip-flop between bits. The slice is external; the top level wires slice_a/slice_b/slice_cin to the slice inputs and slice_sum/slice_cout back to this block.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a new addition; sampled only in IDLE.
op_a  input  WIDTH  operand A, captured on the accepted start.
op_b  input  WIDTH  operand B, captured on the accepted start.
cin_init  input  1  carry-in for bit 0, captured on the accepted start.
slice_a  output  1  current A bit to the slice.
slice_b  output  1  current B bit to the slice.
slice_cin  output  1  current carry to the slice.
slice_sum  input  1  slice sum output, sampled each RUN cycle.
slice_cout  input  1  slice carry output, sampled each RUN cycle.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result is complete.
result  output  WIDTH  sum, valid from done onward; held until the next accepted start.
cout_final  output  1  carry out of the MSB, valid with result.
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB), valid with result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n=0, all state clears immediately: FSM=IDLE, shift registers=0, carry_reg=0, bit counter=0, busy=0, done=0, result=0, cout_final=0, ovf=0, and slice_a/b/cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a clock edge with start=1. On that edge: a_sr<=op_a, b_sr<=op_b, carry_reg<=cin_init, cnt<=0, res_sr<=0.
- RUN: slice_a=a_sr[0], slice_b=b_sr[0], slice_cin=carry_reg. All three are driven combinationally from registers.
- RUN, each edge:
  - res_sr<={slice_sum, res_sr[WIDTH-1:1]} (LSB-first fill, shifting right).
  - carry_reg<=slice_cout.
  - a_sr and b_sr shift right by 1 with 0 fill.
  - cnt<=cnt+1.
  - When cnt==WIDTH-2, also store ovf_c<=slice_cout (carry into the MSB). For WIDTH=1, ovf_c<=cin_init at start.
- RUN -> DONE on the edge where cnt==WIDTH-1 (the last bit). On that edge: result<=final res_sr, cout_final<=slice_cout, ovf<=ovf_c XOR slice_cout.
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE unconditionally.
- Latency: start is sampled at edge E0; busy=1 for cycles E0..E(WIDTH); done=1 in the cycle after edge E(WIDTH). That is WIDTH+1 edges from start to done.
- Outside RUN, slice_a, slice_b and slice_cin are 0.
- start while in RUN or DONE is ignored, with no queuing. start held high continuously restarts from IDLE on the edge after done.
- result, cout_final and ovf are registered and hold their values through IDLE until overwritten at the end of the next operation. They are not cleared by start.
- The slice is a gate-delay model. The clock period must exceed the slice's worst-case propagation (3 NAND levels); the bench uses a period of at least 10x the gate delay.
- Reset mid-RUN aborts the operation, clears all outputs, and returns to IDLE. A start in the first cycle after reset release is accepted normally.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin_init=0 -> done after 9 edges; result=0x96, cout_final=0, ovf=1.
- WIDTH=8, 0xFF+0x01, cin_init=0 -> result=0x00, cout_final=1, ovf=0. Then 0x80+0x80 -> result=0x00, cout_final=1, ovf=1.
- WIDTH=8, 0x00+0x00, cin_init=1 -> result=0x01, cout_final=0. Also check slice_cin=1 in the first RUN cycle only.
- Pulse start again at the 3rd RUN cycle with different operands -> ignored; the original result appears. done is high exactly one cycle and busy is high exactly 8 cycles.
- Drop rst_n at the 4th RUN cycle -> busy, done, result and slice_* go to 0 immediately (asynchronously). After release, a new start with 0x12+0x34 yields 0x46.
- WIDTH=1: 1+1 with cin_init=1 -> result=1, cout_final=1, ovf=0, done 2 edges after start. Back-to-back start held high -> second done occurs 3 edges after the first.
